// File: rtl/cic_ctrl.sv
// rtl/cic_ctrl.sv - CIC sequencing, output scaling/saturation and output FIFO
module cic_ctrl #(
  parameter int CIC_WIDTH   = 50,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 34,
  parameter int FLUSH_COUNT = 15,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mod_valid,
  output logic                 cic_in_valid,
  output logic                 cic_rst_n,
  input  logic                 cic_out_valid,
  input  logic [CIC_WIDTH-1:0] cic_out_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [1:0]           state,
  output logic                 sat_flag,
  output logic                 ovf_flag,
  output logic [7:0]           drop_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FLUSH_COUNT + 1);

  localparam logic signed [CIC_WIDTH:0] ROUND   = {{CIC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [CIC_WIDTH:0] OUT_MAX = {{(CIC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CIC_WIDTH:0] OUT_MIN = {{(CIC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [FW-1:0] flush_cnt;
  logic          flush_done;
  logic          push_req;

  assign state      = state_q;
  assign flush_done = cic_out_valid && (flush_cnt == FW'(FLUSH_COUNT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable wins from any state
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FLUSH;
        S_FLUSH: if (flush_done) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cic_in_valid = 1'b0;
    push_req     = 1'b0;
    case (state_q)
      S_FLUSH: cic_in_valid = mod_valid;
      S_RUN: begin
        cic_in_valid = mod_valid;
        push_req     = cic_out_valid && enable;
      end
      default: begin
        cic_in_valid = 1'b0;
        push_req     = 1'b0;
      end
    endcase
  end

  // CIC reset tracks the state being entered, so it moves on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cic_rst_n <= 1'b0;
    end else begin
      cic_rst_n <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable || (state_q != S_FLUSH)) begin
      flush_cnt <= '0;
    end else if (cic_out_valid) begin
      flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
    end
  end

  // Round half up, arithmetic shift, then clamp to the output range
  logic signed [CIC_WIDTH:0] x_ext;
  logic signed [CIC_WIDTH:0] sum;
  logic signed [CIC_WIDTH:0] y;
  logic                      clamp_hi;
  logic                      clamp_lo;
  logic [OUT_WIDTH-1:0]      scaled;

  always_comb begin
    x_ext    = {cic_out_data[CIC_WIDTH-1], cic_out_data};
    sum      = x_ext + ROUND;
    y        = sum >>> SHIFT;
    clamp_hi = (y > OUT_MAX);
    clamp_lo = (y < OUT_MIN);
    if (clamp_hi) begin
      scaled = OUT_MAX[OUT_WIDTH-1:0];
    end else if (clamp_lo) begin
      scaled = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      scaled = y[OUT_WIDTH-1:0];
    end
  end

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  assign m_valid = (count != '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = m_valid && m_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= scaled;
  end

  // Status is sticky across disable; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push_req && (clamp_hi || clamp_lo)) sat_flag <= 1'b1;
      if (drop) begin
        ovf_flag <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cic_ctrl.sv
// tb/tb_cic_ctrl.sv - directed table-driven bench for cic_ctrl
module tb_cic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mod_valid;
  logic        cic_in_valid;
  logic        cic_rst_n;
  logic        cic_out_valid;
  logic [49:0] cic_out_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  state;
  logic        sat_flag;
  logic        ovf_flag;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  cic_ctrl #(
    .CIC_WIDTH(50), .OUT_WIDTH(16), .SHIFT(34), .FLUSH_COUNT(15), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mod_valid(mod_valid),
    .cic_in_valid(cic_in_valid), .cic_rst_n(cic_rst_n),
    .cic_out_valid(cic_out_valid), .cic_out_data(cic_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .state(state), .sat_flag(sat_flag), .ovf_flag(ovf_flag), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string   name;
    longint  data;
    longint  exp_data;
    longint  exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [49:0] w50(input longint v);
    return v[49:0];
  endfunction

  function automatic longint mdat();
    return longint'($signed(m_data));
  endfunction

  task automatic push(input longint v);
    cic_out_valid = 1'b1;
    cic_out_data  = w50(v);
    tick();
    cic_out_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_cic_rst_n"}, cic_rst_n, 0);
    chk({tag, "_cic_in_valid"}, cic_in_valid, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, mdat(), 0);
    chk({tag, "_sat_flag"}, sat_flag, 0);
    chk({tag, "_ovf_flag"}, ovf_flag, 0);
    chk({tag, "_drop_count"}, drop_count, 0);
  endtask

  // 15 discarded outputs, then the 16th must appear one cycle after its strobe
  task automatic run_flush(input string tag);
    int seen = 0;
    int bad  = 0;
    for (int i = 1; i <= 15; i++) begin
      push(longint'(i) <<< 40);
      if (m_valid) seen++;
      if (state != ((i == 15) ? 2'd2 : 2'd1)) bad++;
      tick();
      if (m_valid) seen++;
    end
    chk({tag, "_flush_no_valid"}, seen, 0);
    chk({tag, "_flush_state"}, bad, 0);
    chk({tag, "_state_run"}, state, 2);
    push(longint'(15) <<< 45);
    chk({tag, "_first_valid"}, m_valid, 1);
    chk({tag, "_first_data"}, mdat(), 30720);
    tick();
    chk({tag, "_first_popped"}, m_valid, 0);
  endtask

  initial begin
    vecs[0] = '{"s_15x2p45",    longint'(15) <<< 45,          30720,  0};
    vecs[1] = '{"s_neg2p49",    -(longint'(1) <<< 49),        -32768, 0};
    vecs[2] = '{"s_2p33",       longint'(1) <<< 33,           1,      0};
    vecs[3] = '{"s_2p33m1",     (longint'(1) <<< 33) - 1,     0,      0};
    vecs[4] = '{"s_neg3x2p33",  -(longint'(3) <<< 33),        -1,     0};
    vecs[5] = '{"s_neg2p33",    -(longint'(1) <<< 33),        0,      0};
    vecs[6] = '{"s_sat_max",    (longint'(1) <<< 49) - 1,     32767,  1};
    vecs[7] = '{"s_after_sat",  longint'(1) <<< 45,           2048,   1};

    rst = 1'b1; enable = 1'b0; mod_valid = 1'b1; m_ready = 1'b1;
    cic_out_valid = 1'b0; cic_out_data = '0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    chk("idle_hold_state", state, 0);

    enable = 1'b1;
    tick();
    chk("en_state_flush", state, 1);
    chk("en_cic_rst_n", cic_rst_n, 1);
    chk("flush_in_valid_hi", cic_in_valid, 1);
    mod_valid = 1'b0;
    #1;
    chk("flush_in_valid_lo", cic_in_valid, 0);
    run_flush("startup");

    for (int i = 0; i < 8; i++) begin
      push(vecs[i].data);
      chk({vecs[i].name, "_valid"}, m_valid, 1);
      chk({vecs[i].name, "_data"}, mdat(), vecs[i].exp_data);
      chk({vecs[i].name, "_sat"}, sat_flag, vecs[i].exp_sat);
      tick();
    end

    // Backpressure: 4 held, 2 dropped, drained in order
    m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(longint'(k) <<< 34);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", mdat(), 1);
    chk("bp_ovf", ovf_flag, 1);
    chk("bp_drop", drop_count, 2);
    tick();
    chk("bp_head_stable", mdat(), 1);
    m_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      #1;
      chk($sformatf("bp_drain_valid%0d", j), m_valid, 1);
      chk($sformatf("bp_drain_data%0d", j), mdat(), j);
      tick();
    end
    chk("bp_empty", m_valid, 0);

    // Full FIFO with simultaneous push and pop
    m_ready = 1'b0;
    for (int k = 11; k <= 14; k++) push(longint'(k) <<< 34);
    m_ready = 1'b1;
    push(longint'(15) <<< 34);
    chk("fpp_drop", drop_count, 2);
    for (int j = 12; j <= 15; j++) begin
      chk($sformatf("fpp_data%0d", j), mdat(), j);
      tick();
    end
    chk("fpp_empty", m_valid, 0);

    // Mid-run disable with 3 queued and a concurrent sample
    m_ready = 1'b0;
    for (int k = 21; k <= 23; k++) push(longint'(k) <<< 34);
    chk("dis_queued_head", mdat(), 21);
    enable = 1'b0;
    push(longint'(24) <<< 34);
    chk("dis_state", state, 0);
    chk("dis_m_valid", m_valid, 0);
    chk("dis_cic_rst_n", cic_rst_n, 0);
    chk("dis_m_data", mdat(), 0);
    mod_valid = 1'b1;
    #1;
    chk("dis_in_valid", cic_in_valid, 0);
    mod_valid = 1'b0;
    tick();
    chk("dis_sample_dropped", m_valid, 0);
    chk("dis_sticky_ovf", ovf_flag, 1);
    chk("dis_sticky_sat", sat_flag, 1);
    chk("dis_sticky_drop", drop_count, 2);

    enable = 1'b1; m_ready = 1'b1;
    tick();
    chk("reen_state", state, 1);
    chk("reen_cic_rst_n", cic_rst_n, 1);
    run_flush("reenable");

    // Reset during RUN with flags set and data queued
    m_ready = 1'b0;
    push(longint'(7) <<< 34);
    chk("prerst_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0; enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
